sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/picomips_pkg.sv | 13 +
 rtl/sw_debounce_sync2.sv | 26 ++
 rtl/sw_debounce.sv | 119 +++++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// Shared constants and FSM state type for the picoMIPS switch conditioning path.
package picomips_pkg;

  localparam int unsigned SW_W_DEFAULT      = 9;
  localparam int unsigned DB_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    COMMIT
  } db_state_t;

endpackage

// File: rtl/sw_debounce_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
    end
  end

  assign q = r_sync2;

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer feeding the picoMIPS SW input.
// SW_DEBOUNCE_EN selects the counting FSM; otherwise the synchronized value is registered directly.
module sw_debounce
  import picomips_pkg::*;
#(
  parameter int unsigned SW_W      = SW_W_DEFAULT,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SW_W-1:0] sw_async,
  output logic [SW_W-1:0] sw_stable,
  output logic            sw_changed,
  output logic            step_pulse,
  output logic            busy
);

  logic [SW_W-1:0] w_sync2;
  logic [SW_W-1:0] r_stable;
  logic            r_changed;
  logic            r_step;

  sync2 #(.WIDTH(SW_W)) u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw_async),
    .q       (w_sync2)
  );

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned       CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_t        r_state, w_state_nxt;
  logic [SW_W-1:0]  r_cand, w_cand_nxt;
  logic [SW_W-1:0]  w_stable_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_changed_nxt;
  logic             w_step_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_changed <= 1'b0;
      r_step    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      r_changed <= w_changed_nxt;
      r_step    <= w_step_nxt;
    end
  end

  // Pulses default low so they last exactly the one cycle after COMMIT.
  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_stable_nxt  = r_stable;
    w_changed_nxt = 1'b0;
    w_step_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync2 != r_stable) begin
          w_cand_nxt  = w_sync2;
          w_cnt_nxt   = '0;
          w_state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (w_sync2 != r_cand) begin
          w_cand_nxt = w_sync2;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = COMMIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      COMMIT: begin
        w_stable_nxt  = r_cand;
        w_changed_nxt = (r_cand != r_stable);
        w_step_nxt    = ~r_stable[SW_W-1] & r_cand[SW_W-1];
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);
`else
  logic w_unused_db;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable  <= '0;
      r_changed <= 1'b0;
      r_step    <= 1'b0;
    end else begin
      r_stable  <= w_sync2;
      r_changed <= (w_sync2 != r_stable);
      r_step    <= ~r_stable[SW_W-1] & w_sync2[SW_W-1];
    end
  end

  assign busy        = 1'b0;
  assign w_unused_db = ^DB_CYCLES;
`endif

  assign sw_stable  = r_stable;
  assign sw_changed = r_changed;
  assign step_pulse = r_step;

endmodule
